// File: rtl/freq_div_pkg.sv
// Shared defaults, channel update actions and the high-time rule for the
// programmable frequency divider.
package freq_div_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_DIV_VAL = 4;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADVANCE,
        ACT_WRAP,
        ACT_DIRECT
    } ch_action_t;

    // High time of a period of d cycles: ceil(d/2)
    function automatic int unsigned hi_time(input int unsigned d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: active divisor, shadow divisor and phase counter, with
// registered clk_out/tick computed from the next-state counter.
module freq_div_ch
    import freq_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] d, s, cnt;
    logic [CNT_W-1:0] d_nxt, s_nxt, cnt_nxt;
    logic             pend_nxt, tick_nxt, clk_nxt, advanced, at_end;
    ch_action_t       action;

    // A disabled channel, or a stopped channel parked on its last phase, has
    // no running period to protect, so a load takes effect at once.
    always_comb begin
        at_end   = (d != '0) && (cnt == d - CNT_W'(1));
        action   = ACT_HOLD;
        d_nxt    = d;
        s_nxt    = s;
        cnt_nxt  = cnt;
        pend_nxt = pending;
        advanced = 1'b0;

        if ((d == '0) || (!en && at_end)) begin
            if (div_load) action = ACT_DIRECT;
        end else if (en) begin
            action = at_end ? ACT_WRAP : ACT_ADVANCE;
        end

        if (div_load) s_nxt = div_in;

        case (action)
            ACT_DIRECT: begin
                d_nxt    = div_in;
                cnt_nxt  = (div_in == '0) ? '0 : div_in - CNT_W'(1);
                pend_nxt = 1'b0;
            end
            ACT_ADVANCE: begin
                cnt_nxt  = cnt + CNT_W'(1);
                advanced = 1'b1;
                if (div_load) pend_nxt = 1'b1;
            end
            ACT_WRAP: begin
                cnt_nxt  = '0;
                advanced = 1'b1;
                pend_nxt = 1'b0;
                if (div_load)     d_nxt = div_in;
                else if (pending) d_nxt = s;
            end
            default: begin
                if (div_load) pend_nxt = 1'b1;
            end
        endcase

        tick_nxt = advanced && (cnt_nxt == '0) && (d_nxt != '0);
        clk_nxt  = (d_nxt != '0) && (32'(cnt_nxt) < hi_time(32'(d_nxt)));
    end

    always_ff @(posedge clk or negedge reset_ah_in) begin
        if (!reset_ah_in) begin
            d       <= CNT_W'(DEF_DIV);
            s       <= CNT_W'(DEF_DIV);
            cnt     <= CNT_W'(DEF_DIV - 1);
            pending <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            d       <= d_nxt;
            s       <= s_nxt;
            cnt     <= cnt_nxt;
            pending <= pend_nxt;
            tick    <= tick_nxt;
            clk_out <= clk_nxt;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel programmable frequency divider; each channel is an independent
// freq_div_ch. Outputs are clock enables / divided levels, never clocks.
module freq_div_prog
    import freq_div_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic                 clk,
    input  logic                 reset_ah_in,
    input  logic                 en,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH*CNT_W-1:0] div_in,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       pending
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        freq_div_ch #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .reset_ah_in(reset_ah_in),
            .en         (en),
            .div_load   (div_load[i]),
            .div_in     (div_in[i*CNT_W +: CNT_W]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: a period-level reference model queues the
// expected outputs per cycle, a monitor pops and compares them.
module tb_freq_div_prog;

    localparam int NCH     = 2;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;

    logic                 clk = 1'b0;
    logic                 reset_ah_in;
    logic                 en;
    logic [NCH-1:0]       div_load;
    logic [NCH*CNT_W-1:0] div_in;
    logic [NCH-1:0]       clk_out, tick, pending;

    typedef struct packed {
        logic [NCH-1:0] clk_out;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pending;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int div_m[NCH];
    int shadow_m[NCH];
    int phase_m[NCH];
    bit pend_m[NCH];
    bit tick_m[NCH];

    freq_div_prog #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .reset_ah_in(reset_ah_in),
        .en         (en),
        .div_load   (div_load),
        .div_in     (div_in),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            div_m[i]    = DEF_DIV;
            shadow_m[i] = DEF_DIV;
            phase_m[i]  = DEF_DIV - 1;
            pend_m[i]   = 1'b0;
            tick_m[i]   = 1'b0;
        end
    endtask

    // One clock of the reference: a period is div_m cycles long, phase_m is the
    // position inside it, and divisor changes only happen between periods.
    task automatic modelStep(input logic e, input logic [NCH-1:0] ld, input logic [NCH*CNT_W-1:0] din);
        for (int i = 0; i < NCH; i++) begin
            int v;
            bit last;
            v         = int'(din[i*CNT_W +: CNT_W]);
            last      = (div_m[i] != 0) && (phase_m[i] == div_m[i] - 1);
            tick_m[i] = 1'b0;
            if (div_m[i] == 0 || (!e && last)) begin
                if (ld[i]) begin
                    div_m[i]    = v;
                    shadow_m[i] = v;
                    pend_m[i]   = 1'b0;
                    phase_m[i]  = (v > 0) ? v - 1 : 0;
                end
            end else if (!e) begin
                if (ld[i]) begin
                    shadow_m[i] = v;
                    pend_m[i]   = 1'b1;
                end
            end else if (last) begin
                phase_m[i] = 0;
                if (ld[i])           div_m[i] = v;
                else if (pend_m[i])  div_m[i] = shadow_m[i];
                if (ld[i]) shadow_m[i] = v;
                pend_m[i] = 1'b0;
                tick_m[i] = (div_m[i] != 0);
            end else begin
                phase_m[i]++;
                if (ld[i]) begin
                    shadow_m[i] = v;
                    pend_m[i]   = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [NCH-1:0] ld, input logic [NCH*CNT_W-1:0] din);
        exp_t x;
        @(negedge clk);
        en       = e;
        div_load = ld;
        div_in   = din;
        modelStep(e, ld, din);
        for (int i = 0; i < NCH; i++) begin
            x.clk_out[i] = (div_m[i] != 0) && (phase_m[i] < (div_m[i] + 1) / 2);
            x.tick[i]    = tick_m[i];
            x.pending[i] = pend_m[i];
        end
        sb.push_back(x);
    endtask

    task automatic assertReset();
        reset_ah_in = 1'b0;
        en          = 1'b0;
        div_load    = '0;
        #1;
        checkOutput("rst_clk_out", 32'(clk_out), 32'd0);
        checkOutput("rst_tick", 32'(tick), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        modelReset();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checkOutput("sb_clk_out", 32'(clk_out), 32'(x.clk_out));
                checkOutput("sb_tick", 32'(tick), 32'(x.tick));
                checkOutput("sb_pending", 32'(pending), 32'(x.pending));
            end
        end
    end

    initial begin : driver
        string            exp_clk, exp_tick, exp_pend;
        logic [NCH-1:0]   ld;
        logic [NCH*CNT_W-1:0] din;
        logic             e;

        exp_clk  = {"110011001", "100111001", "1100110110", "1110001", "1100000", "010111101"};
        exp_tick = {"100010001", "000100001", "0000100100", "1000001", "0000000", "010100001"};
        exp_pend = {"000000000", "111000000", "1111000000", "0000000", "1111100", "000000000"};

        en          = 1'b0;
        div_load    = '0;
        div_in      = '0;
        reset_ah_in = 1'b1;
        #2;
        assertReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ah_in = 1'b1;

        // Directed walk on channel 0: default period, 5, 7-then-3, 6 at the
        // boundary, 0 then 2, and a three-cycle enable gap.
        for (int s = 1; s <= 51; s++) begin
            int val;
            e   = !(s >= 47 && s <= 49);
            ld  = '0;
            din = '0;
            val = -1;
            case (s)
                10: val = 5;
                19: val = 7;
                20: val = 3;
                29: val = 6;
                36: val = 0;
                43: val = 2;
                default: val = -1;
            endcase
            if (val >= 0) begin
                ld[0]          = 1'b1;
                din[CNT_W-1:0] = CNT_W'(val);
            end
            applyStimulus(e, ld, din);
            @(posedge clk);
            #2;
            checkOutput($sformatf("dir_clk_c%0d", s), 32'(clk_out[0]), 32'(exp_clk[s-1] == 8'h31));
            checkOutput($sformatf("dir_tick_c%0d", s), 32'(tick[0]), 32'(exp_tick[s-1] == 8'h31));
            checkOutput($sformatf("dir_pend_c%0d", s), 32'(pending[0]), 32'(exp_pend[s-1] == 8'h31));
        end

        #1;
        assertReset();
        @(negedge clk);
        reset_ah_in = 1'b1;

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                @(posedge clk);
                #3;
                assertReset();
                @(negedge clk);
                reset_ah_in = 1'b1;
            end
            e  = ($urandom_range(0, 7) != 0);
            ld = '0;
            din = '0;
            for (int c = 0; c < NCH; c++) begin
                ld[c] = ($urandom_range(0, 9) == 0);
                din[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            end
            applyStimulus(e, ld, din);
        end

        @(posedge clk);
        #2;
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
